// File: rtl/soc_system_pio_input_irq.sv
// Avalon-MM PIO input slave: synchronised inputs, sticky W1C edge capture, maskable irq.
// readdata is registered (1-cycle latency from address); no wait states, no backpressure.
module soc_system_pio_input_irq #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] WARM_EDGES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_dat;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [2:0]       warm_cnt;
  logic             warm_done;
  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;

  assign sync_dat  = sync_q[SYNC_STAGES-1];
  assign wr_en     = chipselect & ~write_n;
  assign warm_done = (warm_cnt == WARM_EDGES);

  assign rise     = sync_dat & ~prev;
  assign fall     = ~sync_dat & prev;
  assign edge_det = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall : (rise | fall);

  // Edges are ignored until the synchroniser and prev hold real post-reset data.
  assign cap_set = warm_done ? edge_det : '0;
  assign cap_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev         <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      warm_cnt     <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_dat;
      if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
      // Set wins over a simultaneous clear so no edge is lost.
      edge_capture <= (edge_capture & ~cap_clr) | cap_set;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync_dat;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = (IRQ_TYPE == 0) ? |(sync_dat & irq_mask) : |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_input_irq.sv
// Bench for soc_system_pio_input_irq: an edge/rise instance (A) and an any-edge/level instance (B).
module tb_soc_system_pio_input_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          due;
    int          kind;   // 0 rd A, 1 irq A, 2 rd B, 3 irq B
    logic [31:0] exp;
    logic [79:0] nm;
  } ent_t;
  ent_t q[$];

  soc_system_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  soc_system_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_b), .irq(irq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    ent_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = readdata_a;
        1:       act = {31'b0, irq_a};
        2:       act = readdata_b;
        default: act = {31'b0, irq_b};
      endcase
      n_chk++;
      if (e.due != cyc)
        $display("FAIL %s: stale check due %0d seen at %0d", e.nm, e.due, cyc);
      else if (act !== e.exp)
        $display("FAIL %s (kind %0d, cyc %0d): got 0x%08h, expected 0x%08h", e.nm, e.kind, cyc, act, e.exp);
      else
        n_pass++;
    end
  end

  task automatic push(input int kind, input int due, input logic [31:0] exp, input logic [79:0] nm);
    ent_t e;
    e.kind = kind; e.due = due; e.exp = exp; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [79:0] nm);
    address = a;
    push(0, cyc + 1, ea, nm);
    push(2, cyc + 1, eb, nm);
    tick(1);
  endtask

  task automatic irq_chk(input logic ea, input logic eb, input logic [79:0] nm);
    push(1, cyc, {31'b0, ea}, nm);
    push(3, cyc, {31'b0, eb}, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;

    // Reset with input held high, then warm-up.
    tick(3);
    push(0, cyc, 32'h0, "rst_rd"); push(2, cyc, 32'h0, "rst_rd");
    irq_chk(1'b0, 1'b0, "rst_irq");
    reset_n = 1'b1;
    tick(10);
    rd_chk(2'd0, 32'hF, 32'hF, "warm_data");
    rd_chk(2'd3, 32'h0, 32'h0, "warm_cap");
    irq_chk(1'b0, 1'b0, "warm_irq");

    // Bring inputs to 0 and clear the falls B captured.
    in_port = 4'h0;
    tick(4);
    wr(2'd3, 32'hF);
    tick(1);

    // Rising capture with exact latency on addr3.
    address = 2'd3;
    in_port = 4'h5;
    k = cyc;
    push(0, k + 3, 32'h0, "cap_early"); push(2, k + 3, 32'h0, "cap_early");
    push(0, k + 4, 32'h5, "cap_rise");  push(2, k + 4, 32'h5, "cap_rise");
    tick(5);
    in_port = 4'h0;
    tick(5);
    rd_chk(2'd3, 32'h5, 32'h5, "fall_keep");

    // Interrupt and clear.
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h4);
    irq_chk(1'b0, 1'b0, "irq_idle");
    in_port = 4'h4;
    k = cyc;
    push(3, k + 1, 32'h0, "lvl_pre");
    push(1, k + 2, 32'h0, "irq_pre");
    push(3, k + 2, 32'h1, "lvl_on");
    push(1, k + 3, 32'h1, "irq_on");
    tick(4);
    wr(2'd3, 32'h4);
    push(1, cyc, 32'h0, "irq_clr");
    in_port = 4'h5;
    tick(4);
    wr(2'd3, 32'h0);
    rd_chk(2'd3, 32'h1, 32'h1, "w0_noclr");

    // Set/clear collision on bit 0.
    in_port = 4'h4;
    tick(4);
    in_port = 4'h5;
    tick(2);
    wr(2'd3, 32'h1);
    rd_chk(2'd3, 32'h1, 32'h1, "collide");

    // Level-mode irq on B: 5-cycle pulse on bit 1.
    wr(2'd2, 32'h2);
    in_port = 4'h7;
    k = cyc;
    for (int d = 1; d <= 7; d++)
      push(3, k + d, {31'b0, (d >= 2 && d <= 6)}, "lvl_pulse");
    tick(5);
    in_port = 4'h5;
    tick(3);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_chk(2'd2, 32'h2, 32'h2, "ro_mask");
    rd_chk(2'd3, 32'h3, 32'h3, "ro_cap");
    rd_chk(2'd0, 32'h5, 32'h5, "ro_data");
    rd_chk(2'd1, 32'h0, 32'h0, "rsvd");

    // Any-edge on bit 3, then asynchronous reset mid-cycle.
    wr(2'd3, 32'hF);
    in_port = 4'hD;
    tick(4);
    rd_chk(2'd3, 32'h8, 32'h8, "any_rise");
    wr(2'd3, 32'h8);
    in_port = 4'h5;
    tick(4);
    rd_chk(2'd3, 32'h0, 32'h8, "any_fall");
    wr(2'd2, 32'h8);
    in_port = 4'hD;
    tick(4);
    irq_chk(1'b1, 1'b1, "pre_rst");
    rd_chk(2'd0, 32'hD, 32'hD, "pre_rst_d");
    tick(1);
    reset_n = 1'b0;
    push(0, cyc, 32'h0, "arst_rd"); push(2, cyc, 32'h0, "arst_rd");
    irq_chk(1'b0, 1'b0, "arst_irq");
    tick(2);
    reset_n = 1'b1;
    tick(10);
    rd_chk(2'd3, 32'h0, 32'h0, "rewarm_cap");
    irq_chk(1'b0, 1'b0, "rewarm_irq");
    rd_chk(2'd0, 32'hD, 32'hD, "rewarm_d");
    rd_chk(2'd2, 32'h0, 32'h0, "rewarm_msk");

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks never came due", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
